dmem_arbiter: RTL and testbench

//  Shares the single data-memory port (ROM 400..8499, RAM 8500..138099) between two requesters.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/rr_pick2.sv | 36 +++
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Data-memory map constants, request payload and arbiter state encoding,
// shared by the arbiter and the memory controller.
package dmem_pkg;

    localparam int unsigned DMEM_AW       = 32;
    localparam int unsigned DMEM_DW       = 32;
    localparam int unsigned DMEM_ROM_BASE = 400;
    localparam int unsigned DMEM_RAM_BASE = 8500;
    localparam int unsigned DMEM_MAP_END  = 138100;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic               we;
        logic [DMEM_AW-1:0] addr;
        logic [DMEM_DW-1:0] wd;
    } dmem_req_t;

    // Unmapped address, or a write that lands in ROM.
    function automatic logic dmem_access_err(
        input logic [DMEM_AW-1:0] addr,
        input logic               we,
        input logic [DMEM_AW-1:0] rom_base,
        input logic [DMEM_AW-1:0] ram_base,
        input logic [DMEM_AW-1:0] map_end
    );
        return (addr < rom_base) || (addr >= map_end) || (we && (addr < ram_base));
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-port winner selection with bounded repeat priority for port 0,
// plus the burst counter value that goes with the chosen winner.
module rr_pick2 #(
    parameter int unsigned P0_BURST = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic [1:0]       req,
    input  logic             last_grant,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic             winner_c,
    output logic [CNT_W-1:0] burst_nxt_c
);

    always_comb begin
        winner_c    = 1'b0;
        burst_nxt_c = CNT_W'(1);
        if (req == 2'b11) begin
            if (!last_grant && (burst_cnt < CNT_W'(P0_BURST))) begin
                winner_c = 1'b0;
            end else begin
                winner_c = ~last_grant;
            end
        end else begin
            winner_c = req[1];
        end
        // Saturating count of consecutive grants to the same port.
        if (winner_c == last_grant) begin
            if (burst_cnt < CNT_W'(P0_BURST)) begin
                burst_nxt_c = burst_cnt + CNT_W'(1);
            end else begin
                burst_nxt_c = burst_cnt;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the MEM stage (port 0) and
// the bulk loader (port 1); one transaction in flight, ROM/unmapped checks.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned ROM_BASE = DMEM_ROM_BASE,
    parameter int unsigned RAM_BASE = DMEM_RAM_BASE,
    parameter int unsigned MAP_END  = DMEM_MAP_END,
    parameter int unsigned P0_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_i,
    input  logic [1:0]         we_i,
    input  logic [DMEM_AW-1:0] addr0_i,
    input  logic [DMEM_AW-1:0] addr1_i,
    input  logic [DMEM_DW-1:0] wd0_i,
    input  logic [DMEM_DW-1:0] wd1_i,
    output logic [1:0]         ack_o,
    output logic               err_o,
    output logic [DMEM_DW-1:0] rd_o,
    output logic               mem_we,
    output logic [DMEM_AW-1:0] mem_addr,
    output logic [DMEM_AW-1:0] mem_wd,
    input  logic [DMEM_DW-1:0] mem_rd
);

    localparam int unsigned CNT_W = $clog2(P0_BURST + 1);
    localparam int unsigned LAT_W = 2;

    arb_state_t         state_q, state_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   burst_q, burst_d;
    logic               grant_q, grant_d;
    logic               we_q, we_d;
    logic               bad_q, bad_d;
    logic [LAT_W-1:0]   lat_q, lat_d;

    logic [1:0]         ack_d;
    logic               err_d;
    logic [DMEM_DW-1:0] rd_d;
    logic               mem_we_d;
    logic [DMEM_AW-1:0] mem_addr_d;
    logic [DMEM_DW-1:0] mem_wd_d;

    logic               pick_c;
    logic [CNT_W-1:0]   pick_burst_c;
    dmem_req_t          sel_req_c;
    logic               sel_bad_c;

    rr_pick2 #(
        .P0_BURST (P0_BURST),
        .CNT_W    (CNT_W)
    ) u_pick (
        .req         (req_i),
        .last_grant  (last_q),
        .burst_cnt   (burst_q),
        .winner_c    (pick_c),
        .burst_nxt_c (pick_burst_c)
    );

    // Winner payload mux and access classification.
    always_comb begin
        if (pick_c) begin
            sel_req_c.we   = we_i[1];
            sel_req_c.addr = addr1_i;
            sel_req_c.wd   = wd1_i;
        end else begin
            sel_req_c.we   = we_i[0];
            sel_req_c.addr = addr0_i;
            sel_req_c.wd   = wd0_i;
        end
        sel_bad_c = dmem_access_err(sel_req_c.addr, sel_req_c.we,
                                    DMEM_AW'(ROM_BASE), DMEM_AW'(RAM_BASE), DMEM_AW'(MAP_END));
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        burst_d    = burst_q;
        grant_d    = grant_q;
        we_d       = we_q;
        bad_d      = bad_q;
        lat_d      = lat_q;
        ack_d      = 2'b00;
        err_d      = 1'b0;
        rd_d       = '0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr;
        mem_wd_d   = mem_wd;
        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    grant_d    = pick_c;
                    last_d     = pick_c;
                    burst_d    = pick_burst_c;
                    we_d       = sel_req_c.we;
                    bad_d      = sel_bad_c;
                    mem_addr_d = sel_bad_c ? '0 : sel_req_c.addr;
                    mem_we_d   = sel_req_c.we & ~sel_bad_c;
                    mem_wd_d   = sel_req_c.wd;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                // Errors and writes need no read data; single-cycle reads are ready in RESP.
                if (bad_q || we_q || (RD_LAT == 1)) begin
                    state_d = RESP;
                end else begin
                    lat_d   = LAT_W'(RD_LAT - 2);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (lat_q == '0) begin
                    state_d = RESP;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RESP: begin
                ack_d   = grant_q ? 2'b10 : 2'b01;
                err_d   = bad_q;
                rd_d    = (we_q || bad_q) ? '0 : mem_rd;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            burst_q  <= '0;
            grant_q  <= 1'b0;
            we_q     <= 1'b0;
            bad_q    <= 1'b0;
            lat_q    <= '0;
            ack_o    <= 2'b00;
            err_o    <= 1'b0;
            rd_o     <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_wd   <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            burst_q  <= burst_d;
            grant_q  <= grant_d;
            we_q     <= we_d;
            bad_q    <= bad_d;
            lat_q    <= lat_d;
            ack_o    <= ack_d;
            err_o    <= err_d;
            rd_o     <= rd_d;
            mem_we   <= mem_we_d;
            mem_addr <= mem_addr_d;
            mem_wd   <= mem_wd_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with RD_LAT=1 and a RAM model,
// one with RD_LAT=3 and an address-derived read pattern.
module tb_dmem_arbiter;

    localparam int unsigned MEM_AW = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int we_pulses = 0;

    // Instance with single-cycle read latency
    logic        rst_n;
    logic [1:0]  req, we;
    logic [31:0] addr0, addr1, wd0, wd1;
    logic [1:0]  ack;
    logic        err;
    logic [31:0] rd;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    // Instance with three-cycle read latency
    logic        rst3_n;
    logic [1:0]  req3, we3;
    logic [31:0] addr0_3, addr1_3, wd0_3, wd1_3;
    logic [1:0]  ack3;
    logic        err3;
    logic [31:0] rd3;
    logic        mem_we3;
    logic [31:0] mem_addr3, mem_wd3, mem_rd3;

    dmem_arbiter #(.RD_LAT(1), .P0_BURST(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we),
        .addr0_i(addr0), .addr1_i(addr1), .wd0_i(wd0), .wd1_i(wd1),
        .ack_o(ack), .err_o(err), .rd_o(rd),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    dmem_arbiter #(.RD_LAT(3), .P0_BURST(4)) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .req_i(req3), .we_i(we3),
        .addr0_i(addr0_3), .addr1_i(addr1_3), .wd0_i(wd0_3), .wd1_i(wd1_3),
        .ack_o(ack3), .err_o(err3), .rd_o(rd3),
        .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wd(mem_wd3), .mem_rd(mem_rd3)
    );

    // RAM model: synchronous read, one cycle; preload port for the bench.
    logic [31:0] mem [0:(1<<MEM_AW)-1];
    logic        pl_en = 1'b0;
    logic [31:0] pl_addr = '0, pl_data = '0;
    logic [31:0] rd_pipe = '0;
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr[MEM_AW-1:0]] <= pl_data;
        else if (mem_we) mem[mem_addr[MEM_AW-1:0]] <= mem_wd;
        if (mem_we) we_pulses <= we_pulses + 1;
        rd_pipe <= mem[mem_addr[MEM_AW-1:0]];
    end
    assign mem_rd = rd_pipe;

    // Three-stage read pipe returning addr ^ A5A50000.
    logic [31:0] rd3_p0 = '0, rd3_p1 = '0, rd3_p2 = '0;
    always @(posedge clk) begin
        rd3_p0 <= mem_addr3 ^ 32'hA5A5_0000;
        rd3_p1 <= rd3_p0;
        rd3_p2 <= rd3_p1;
    end
    assign mem_rd3 = rd3_p2;

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(posedge clk); #1;
        pl_en   = 1'b0;
    endtask

    // Drives one request on the first instance and waits (bounded) for its ack.
    task automatic run_txn(input logic port, input logic w, input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic [1:0] ack_v, output logic err_v,
                           output logic [31:0] rd_v);
        lat = -1; ack_v = 2'b00; err_v = 1'b0; rd_v = '0;
        req[port] = 1'b1;
        we[port]  = w;
        if (port) begin addr1 = a; wd1 = d; end
        else begin addr0 = a; wd0 = d; end
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ack !== 2'b00) begin
                lat = i; ack_v = ack; err_v = err; rd_v = rd;
                break;
            end
        end
        req[port] = 1'b0;
        we[port]  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst3_n = 1'b0;
        req = '0; we = '0; addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
        req3 = '0; we3 = '0; addr0_3 = '0; addr1_3 = '0; wd0_3 = '0; wd1_3 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({ack, err, mem_we, rd, mem_addr, mem_wd} !== 100'd0) begin errors++;
            $display("FAIL reset_outputs: got %h expected 0", {ack, err, mem_we, rd, mem_addr, mem_wd}); end
        checks++; if ({ack3, err3, mem_we3, rd3, mem_addr3, mem_wd3} !== 100'd0) begin errors++;
            $display("FAIL reset_outputs3: got %h expected 0", {ack3, err3, mem_we3, rd3, mem_addr3, mem_wd3}); end
        rst_n = 1'b1; rst3_n = 1'b1;
        @(posedge clk); #1;
        checks++; if ({ack, mem_we, mem_addr} !== 35'd0) begin errors++;
            $display("FAIL idle_outputs: got %h expected 0", {ack, mem_we, mem_addr}); end
    endtask

    task automatic test_single_read();
        int lat; logic [1:0] a; logic e; logic [31:0] r;
        preload(32'd8500, 32'hDEAD_BEEF);
        run_txn(1'b0, 1'b0, 32'd8500, 32'd0, lat, a, e, r);
        checks++; if (lat != 3) begin errors++; $display("FAIL read_lat: got %0d expected 3", lat); end
        checks++; if (a !== 2'b01) begin errors++; $display("FAIL read_ack: got %b expected 01", a); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL read_err: got %b expected 0", e); end
        checks++; if (r !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_data: got %h expected deadbeef", r); end
    endtask

    task automatic test_write_readback();
        int lat; int w0; logic [1:0] a; logic e; logic [31:0] r;
        w0 = we_pulses;
        req = 2'b10; we = 2'b10; addr1 = 32'd8504; wd1 = 32'h1234_5678;
        @(posedge clk); #1;
        checks++; if ({mem_we, mem_addr, mem_wd} !== {1'b1, 32'd8504, 32'h1234_5678}) begin errors++;
            $display("FAIL wr_issue: got we=%b addr=%0d wd=%h expected we=1 addr=8504 wd=12345678", mem_we, mem_addr, mem_wd); end
        @(posedge clk); #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL wr_we_drop: got %b expected 0", mem_we); end
        checks++; if (ack !== 2'b00) begin errors++; $display("FAIL wr_early_ack: got %b expected 00", ack); end
        @(posedge clk); #1;
        checks++; if ({ack, err, rd} !== {2'b10, 1'b0, 32'd0}) begin errors++;
            $display("FAIL wr_ack: got ack=%b err=%b rd=%h expected ack=10 err=0 rd=0", ack, err, rd); end
        req = 2'b00; we = 2'b00;
        checks++; if (we_pulses - w0 != 1) begin errors++; $display("FAIL wr_we_cycles: got %0d expected 1", we_pulses - w0); end
        run_txn(1'b1, 1'b0, 32'd8504, 32'd0, lat, a, e, r);
        checks++; if ({a, e} !== 3'b100 || lat != 3) begin errors++;
            $display("FAIL rb_ack: got ack=%b err=%b lat=%0d expected ack=10 err=0 lat=3", a, e, lat); end
        checks++; if (r !== 32'h1234_5678) begin errors++; $display("FAIL rb_data: got %h expected 12345678", r); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_seq;
        logic [1:0] got;
        exp_seq = 10'b10_0001_0000;
        req = 2'b11; we = 2'b00; addr0 = 32'd8500; addr1 = 32'd8504;
        for (int k = 0; k < 10; k++) begin
            got = 2'b00;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk); #1;
                if (ack !== 2'b00) begin got = ack; break; end
            end
            checks++; if (got !== {exp_seq[k], ~exp_seq[k]}) begin errors++;
                $display("FAIL grant_seq[%0d]: got ack=%b expected ack=%b", k, got, {exp_seq[k], ~exp_seq[k]}); end
        end
        req = 2'b00;
    endtask

    task automatic test_errors();
        int lat; int w0; logic [1:0] a; logic e; logic [31:0] r;
        w0 = we_pulses;
        run_txn(1'b0, 1'b1, 32'd400, 32'hBAD0_0001, lat, a, e, r);
        checks++; if ({a, e, r} !== {2'b01, 1'b1, 32'd0} || lat != 3) begin errors++;
            $display("FAIL rom_write: got ack=%b err=%b rd=%h lat=%0d expected ack=01 err=1 rd=0 lat=3", a, e, r, lat); end
        run_txn(1'b1, 1'b0, 32'd200, 32'd0, lat, a, e, r);
        checks++; if ({a, e, r} !== {2'b10, 1'b1, 32'd0} || lat != 3) begin errors++;
            $display("FAIL unmapped_read: got ack=%b err=%b rd=%h lat=%0d expected ack=10 err=1 rd=0 lat=3", a, e, r, lat); end
        run_txn(1'b1, 1'b1, 32'd8499, 32'hBAD0_0002, lat, a, e, r);
        checks++; if ({a, e} !== 3'b101) begin errors++;
            $display("FAIL rom_top_write: got ack=%b err=%b expected ack=10 err=1", a, e); end
        run_txn(1'b0, 1'b1, 32'd138100, 32'hBAD0_0003, lat, a, e, r);
        checks++; if ({a, e} !== 3'b011) begin errors++;
            $display("FAIL unmapped_write: got ack=%b err=%b expected ack=01 err=1", a, e); end
        checks++; if (we_pulses != w0) begin errors++; $display("FAIL err_no_we: got %0d expected %0d", we_pulses, w0); end
    endtask

    task automatic test_boundaries();
        int lat; logic [1:0] a; logic e; logic [31:0] r;
        preload(32'd138099, 32'hCAFE_F00D);
        preload(32'd8499, 32'h0B0B_0B0B);
        preload(32'd400, 32'h0404_0404);
        run_txn(1'b0, 1'b0, 32'd138099, 32'd0, lat, a, e, r);
        checks++; if ({e, r} !== {1'b0, 32'hCAFE_F00D}) begin errors++;
            $display("FAIL rd_map_top: got err=%b rd=%h expected err=0 rd=cafef00d", e, r); end
        run_txn(1'b0, 1'b0, 32'd138100, 32'd0, lat, a, e, r);
        checks++; if ({a, e, r} !== {2'b01, 1'b1, 32'd0}) begin errors++;
            $display("FAIL rd_map_end: got ack=%b err=%b rd=%h expected ack=01 err=1 rd=0", a, e, r); end
        run_txn(1'b1, 1'b0, 32'd8499, 32'd0, lat, a, e, r);
        checks++; if ({a, e, r} !== {2'b10, 1'b0, 32'h0B0B_0B0B}) begin errors++;
            $display("FAIL rd_rom_top: got ack=%b err=%b rd=%h expected ack=10 err=0 rd=0b0b0b0b", a, e, r); end
        run_txn(1'b0, 1'b0, 32'd400, 32'd0, lat, a, e, r);
        checks++; if ({e, r} !== {1'b0, 32'h0404_0404}) begin errors++;
            $display("FAIL rd_rom_base: got err=%b rd=%h expected err=0 rd=04040404", e, r); end
        run_txn(1'b0, 1'b0, 32'd399, 32'd0, lat, a, e, r);
        checks++; if ({e, r} !== {1'b1, 32'd0}) begin errors++;
            $display("FAIL rd_below_rom: got err=%b rd=%h expected err=1 rd=0", e, r); end
        run_txn(1'b1, 1'b1, 32'd8500, 32'h5555_AAAA, lat, a, e, r);
        checks++; if ({a, e} !== 3'b100 || lat != 3) begin errors++;
            $display("FAIL wr_ram_base: got ack=%b err=%b lat=%0d expected ack=10 err=0 lat=3", a, e, lat); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [1:0] got; logic [31:0] r; logic [1:0] acc;
        // Plain three-cycle read, then a write that skips WAIT.
        req3 = 2'b01; we3 = 2'b00; addr0_3 = 32'd9000;
        lat = -1; got = 2'b00; r = '0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (ack3 !== 2'b00) begin lat = i; got = ack3; r = rd3; break; end
        end
        req3 = 2'b00;
        checks++; if (lat != 5 || got !== 2'b01) begin errors++;
            $display("FAIL lat3_read: got lat=%0d ack=%b expected lat=5 ack=01", lat, got); end
        checks++; if (r !== (32'd9000 ^ 32'hA5A5_0000)) begin errors++;
            $display("FAIL lat3_data: got %h expected %h", r, 32'd9000 ^ 32'hA5A5_0000); end
        req3 = 2'b01; we3 = 2'b01; addr0_3 = 32'd9004; wd0_3 = 32'h0000_0077;
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (ack3 !== 2'b00) begin lat = i; break; end
        end
        req3 = 2'b00; we3 = 2'b00;
        checks++; if (lat != 3) begin errors++; $display("FAIL lat3_write: got lat=%0d expected 3", lat); end

        // Abort a read while it sits in WAIT.
        req3 = 2'b01; addr0_3 = 32'd9100;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (mem_addr3 !== 32'd9100 || ack3 !== 2'b00) begin errors++;
            $display("FAIL pre_abort: got addr=%0d ack=%b expected addr=9100 ack=00", mem_addr3, ack3); end
        rst3_n = 1'b0;
        req3 = 2'b11; addr1_3 = 32'd9200;
        #1;
        checks++; if ({ack3, err3, mem_we3, rd3, mem_addr3, mem_wd3} !== 100'd0) begin errors++;
            $display("FAIL abort_outputs: got %h expected 0", {ack3, err3, mem_we3, rd3, mem_addr3, mem_wd3}); end
        acc = 2'b00;
        repeat (3) begin @(posedge clk); #1; acc = acc | ack3; end
        checks++; if (acc !== 2'b00) begin errors++; $display("FAIL abort_no_ack: got %b expected 00", acc); end
        rst3_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (mem_addr3 !== 32'd9100) begin errors++;
            $display("FAIL post_reset_grant: got addr=%0d expected 9100", mem_addr3); end
        lat = -1; got = 2'b00; r = '0;
        for (int i = 2; i <= 12; i++) begin
            @(posedge clk); #1;
            if (ack3 !== 2'b00) begin lat = i; got = ack3; r = rd3; break; end
        end
        req3[0] = 1'b0;
        checks++; if (lat != 5 || got !== 2'b01 || r !== (32'd9100 ^ 32'hA5A5_0000)) begin errors++;
            $display("FAIL post_reset_p0: got lat=%0d ack=%b rd=%h expected lat=5 ack=01 rd=%h",
                     lat, got, r, 32'd9100 ^ 32'hA5A5_0000); end
        got = 2'b00; r = '0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (ack3 !== 2'b00) begin got = ack3; r = rd3; break; end
        end
        req3 = 2'b00;
        checks++; if (got !== 2'b10 || r !== (32'd9200 ^ 32'hA5A5_0000)) begin errors++;
            $display("FAIL post_reset_p1: got ack=%b rd=%h expected ack=10 rd=%h", got, r, 32'd9200 ^ 32'hA5A5_0000); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_readback();
        test_back_to_back();
        test_errors();
        test_boundaries();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
